fv_dec_scale_round: RTL



---
 rtl/fv_dec_scale_round.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/fv_dec_scale_round.sv
// FV decrypt scale-and-round: m = round(T*x/Q) mod T, one coefficient at a time.
// A restoring divider produces one quotient bit per cycle. Each coefficient
// goes through IDLE (accept) -> DIV (TW+1 cycles) -> OUT (hold until taken).
module fv_dec_scale_round #(
    parameter int N  = 4,
    parameter int QW = 5,
    parameter int Q  = 31,
    parameter int TW = 2,
    parameter int T  = 4
) (
    input  logic          clk,
    input  logic          s_rst_n,
    input  logic          c_vld,
    output logic          c_rdy,
    input  logic          c_last,
    input  logic [QW-1:0] c_data,
    output logic          m_vld,
    input  logic          m_rdy,
    output logic          m_last,
    output logic [TW-1:0] m_data,
    output logic          err_len
);

    localparam int NW = QW + TW + 1;             // numerator width
    localparam int SW = TW + 1;                  // quotient width / divide steps
    localparam int CW = $clog2(SW + 1);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    typedef enum logic [1:0] {IDLE, DIV, OUT} state_t;

    state_t        state, state_nxt;
    logic [QW-1:0] rem;       // partial remainder, always < Q
    logic [SW-1:0] sh;        // low numerator bits shift out, quotient bits shift in
    logic [CW-1:0] step;
    logic          last_q;
    logic [IW-1:0] idx;

    logic          acc;
    logic [QW:0]   cd_ext, cd_sub;
    logic [QW-1:0] xr;
    logic [NW-1:0] num;
    logic [QW:0]   trial, trial_sub;
    logic          q_bit;
    logic [QW-1:0] rem_nxt;
    logic [SW-1:0] qt;
    logic          div_done;

    assign acc = (state == IDLE) && c_vld && c_rdy;

    // Input reduction and rounding-biased numerator. A single conditional
    // subtract is enough because the input is below 2^QW < 2*Q.
    always_comb begin
        cd_ext = {1'b0, c_data};
        cd_sub = cd_ext - (QW+1)'(Q);
        xr     = (cd_ext >= (QW+1)'(Q)) ? cd_sub[QW-1:0] : c_data;
        num    = NW'(T) * {{(NW-QW){1'b0}}, xr} + NW'(Q / 2);
    end

    // One restoring-division step. The top QW numerator bits are already
    // below Q (num < (T+1)*Q <= 2^SW*Q), so SW steps produce the full quotient.
    always_comb begin
        trial     = {rem, sh[SW-1]};
        trial_sub = trial - (QW+1)'(Q);
        q_bit     = (trial >= (QW+1)'(Q));
        rem_nxt   = q_bit ? trial_sub[QW-1:0] : trial[QW-1:0];
        qt        = {sh[SW-2:0], q_bit};
        div_done  = (step == CW'(SW - 1));
    end

    // State register.
    always_ff @(posedge clk or negedge s_rst_n) begin
        if (!s_rst_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (acc)      state_nxt = DIV;
            DIV:     if (div_done) state_nxt = OUT;
            OUT:     if (m_rdy)    state_nxt = IDLE;
            default:               state_nxt = IDLE;
        endcase
    end

    // Datapath and handshake registers.
    always_ff @(posedge clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            c_rdy  <= 1'b0;
            m_vld  <= 1'b0;
            m_last <= 1'b0;
            m_data <= '0;
            rem    <= '0;
            sh     <= '0;
            step   <= '0;
            last_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (acc) begin
                        rem    <= num[NW-1:SW];
                        sh     <= num[SW-1:0];
                        last_q <= c_last;
                        step   <= '0;
                        c_rdy  <= 1'b0;
                    end else begin
                        c_rdy  <= 1'b1;
                    end
                end
                DIV: begin
                    rem  <= rem_nxt;
                    sh   <= qt;
                    step <= step + 1'b1;
                    if (div_done) begin
                        m_vld  <= 1'b1;
                        m_last <= last_q;
                        // quotient equal to T is the mod-T wrap to zero
                        m_data <= (qt == SW'(T)) ? '0 : qt[TW-1:0];
                    end
                end
                OUT: begin
                    if (m_rdy) begin
                        m_vld <= 1'b0;
                        c_rdy <= 1'b1;
                    end
                end
                default: c_rdy <= 1'b0;
            endcase
        end
    end

    // Packet framing: index tracking and sticky length error.
    always_ff @(posedge clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            idx     <= '0;
            err_len <= 1'b0;
        end else if (acc) begin
            if (c_last != (idx == LAST_IDX)) err_len <= 1'b1;
            if (c_last || idx == LAST_IDX)   idx <= '0;
            else                             idx <= idx + 1'b1;
        end
    end

endmodule
